// File: rtl/framebuffer_writer.sv
// Framebuffer writer: buffers shaded pixels in a small FIFO and writes them to
// memory in raster order, flagging frame completion and dropped pixels.
module framebuffer_writer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int RGB_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [3*RGB_WIDTH-1:0]   color_in,
    input  logic                     color_valid_in,
    output logic                     color_ready_out,
    output logic [ADDR_WIDTH-1:0]    fb_addr_out,
    output logic [3*RGB_WIDTH-1:0]   fb_data_out,
    output logic                     fb_we_out,
    input  logic                     fb_ack_in,
    output logic                     busy_out,
    output logic                     frame_done_out,
    output logic                     overflow_out
);

    localparam int PIX_W = 3 * RGB_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(H_RES * V_RES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE   = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [PIX_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_count;
    logic [CNT_W-1:0]     in_count;
    logic [ADDR_WIDTH-1:0] addr;
    logic                 overflow;

    logic fifo_full;
    logic fifo_empty;
    logic accepting;
    logic writing;
    logic ready;
    logic push;
    logic pop;
    logic drop;
    logic we;

    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    assign accepting  = (state == ACTIVE);
    assign writing    = (state == ACTIVE) || (state == DRAIN);
    assign ready      = accepting && !fifo_full;
    assign push       = color_valid_in && ready;
    assign drop       = accepting && color_valid_in && fifo_full;
    assign we         = writing && !fifo_empty;
    assign pop        = we && fb_ack_in;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (frame_start) state_next = ACTIVE;
            ACTIVE: if (push && (in_count == LAST_PIXEL)) state_next = DRAIN;
            // Leave as soon as the FIFO is, or is about to become, empty.
            DRAIN:  if (fifo_empty || (pop && (fifo_count == FIFO_ONE))) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Storage array carries no reset; the read port is gated while empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= color_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_count <= '0;
            addr     <= '0;
            overflow <= 1'b0;
        end else if ((state == IDLE) && frame_start) begin
            in_count <= '0;
            addr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) in_count <= in_count + 1'b1;
            if (pop)  addr     <= addr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    assign color_ready_out = ready;
    assign fb_we_out       = we;
    assign fb_addr_out     = addr;
    assign fb_data_out     = we ? fifo_mem[rd_ptr] : '0;
    assign busy_out        = writing;
    assign frame_done_out  = (state == DONE);
    assign overflow_out    = overflow;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: a 4x2 instance for the detailed
// scenarios and a default 320x240 instance for a full-size frame.
module tb_framebuffer_writer;

    localparam int BIG_PIX = 320 * 240;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [23:0] color_in;
    logic        color_valid_in;
    logic        color_ready_out;
    logic [16:0] fb_addr_out;
    logic [23:0] fb_data_out;
    logic        fb_we_out;
    logic        fb_ack_in;
    logic        busy_out;
    logic        frame_done_out;
    logic        overflow_out;

    logic        b_frame_start;
    logic [23:0] b_color;
    logic        b_valid;
    logic        b_ready;
    logic [16:0] b_addr;
    logic [23:0] b_data;
    logic        b_we;
    logic        b_ack;
    logic        b_busy;
    logic        b_done;
    logic        b_ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ack_cyc = 0;
    int first_ack_cyc = 0;
    int writes = 0;
    int exp_addr = 0;
    int sent = 0;
    logic acc;
    logic [23:0] exp_q[$];

    int b_sent = 0;
    int b_writes = 0;
    int b_err = 0;
    int b_done_cnt = 0;
    int b_post = 0;
    logic [16:0] b_last_addr = '0;

    always #5 clk = ~clk;

    framebuffer_writer #(.H_RES(4), .V_RES(2), .RGB_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(17)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .color_in(color_in), .color_valid_in(color_valid_in), .color_ready_out(color_ready_out),
        .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_we_out(fb_we_out),
        .fb_ack_in(fb_ack_in), .busy_out(busy_out), .frame_done_out(frame_done_out),
        .overflow_out(overflow_out)
    );

    framebuffer_writer dut_big (
        .clk(clk), .reset(reset), .frame_start(b_frame_start),
        .color_in(b_color), .color_valid_in(b_valid), .color_ready_out(b_ready),
        .fb_addr_out(b_addr), .fb_data_out(b_data), .fb_we_out(b_we),
        .fb_ack_in(b_ack), .busy_out(b_busy), .frame_done_out(b_done),
        .overflow_out(b_ovf)
    );

    function automatic logic [23:0] pix(input int i);
        return {i[7:0], 8'(2 * i), 8'(3 * i)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, score any write/push it causes, then advance.
    task automatic applyStimulus(input logic fs, input logic valid, input logic [23:0] color, input logic ack);
        frame_start    = fs;
        color_valid_in = valid;
        color_in       = color;
        fb_ack_in      = ack;
        cyc++;
        if (frame_done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fb_we_out && fb_ack_in) begin
            if (exp_q.size() == 0) begin
                checkOutput("wr_spurious", 32'(fb_we_out), 32'd0);
            end else begin
                checkOutput("wr_addr", 32'(fb_addr_out), exp_addr);
                checkOutput("wr_data", 32'(fb_data_out), 32'(exp_q.pop_front()));
            end
            if (writes == 0) first_ack_cyc = cyc;
            last_ack_cyc = cyc;
            exp_addr++;
            writes++;
        end
        if (color_valid_in && color_ready_out) exp_q.push_back(color_in);
        @(negedge clk);
    endtask

    task automatic startFrame();
        exp_q.delete();
        exp_addr = 0;
        writes   = 0;
        done_cnt = 0;
        sent     = 0;
        applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(color_ready_out), 0);
        checkOutput({tag, "_we"},    32'(fb_we_out), 0);
        checkOutput({tag, "_addr"},  32'(fb_addr_out), 0);
        checkOutput({tag, "_data"},  32'(fb_data_out), 0);
        checkOutput({tag, "_busy"},  32'(busy_out), 0);
        checkOutput({tag, "_done"},  32'(frame_done_out), 0);
        checkOutput({tag, "_ovf"},   32'(overflow_out), 0);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0; color_valid_in = 1'b0; color_in = '0; fb_ack_in = 1'b0;
        b_frame_start = 1'b0; b_valid = 1'b0; b_color = '0; b_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkAllZero("rst");

        // Pixels offered while idle must vanish without a trace.
        repeat (3) applyStimulus(1'b0, 1'b1, pix(9), 1'b1);
        checkOutput("ign_we", 32'(fb_we_out), 0);
        checkOutput("ign_ready", 32'(color_ready_out), 0);
        checkOutput("ign_ovf", 32'(overflow_out), 0);
        checkOutput("ign_queue", exp_q.size(), 0);

        // Full frame, no stall.
        startFrame();
        checkOutput("t1_busy", 32'(busy_out), 1);
        checkOutput("t1_ready0", 32'(color_ready_out), 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t1_ready", 32'(color_ready_out), 1);
            applyStimulus(1'b0, 1'b1, pix(i), 1'b1);
        end
        for (int k = 0; k < 10 && done_cnt == 0; k++) applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
        checkOutput("t1_writes", writes, 8);
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_done_lat", done_cyc - last_ack_cyc, 1);
        checkOutput("t1_rate", last_ack_cyc - first_ack_cyc, 7);
        checkOutput("t1_busy_end", 32'(busy_out), 0);
        checkOutput("t1_done_end", 32'(frame_done_out), 0);
        checkOutput("t1_addr_end", 32'(fb_addr_out), 8);

        // Memory stall: valid held high with no ack.
        startFrame();
        for (int k = 0; k < 10; k++) begin
            acc = color_ready_out;
            applyStimulus(1'b0, 1'b1, pix(sent), 1'b0);
            if (acc) sent++;
        end
        checkOutput("t2_accepted", sent, 4);
        checkOutput("t2_ready", 32'(color_ready_out), 0);
        checkOutput("t2_we", 32'(fb_we_out), 1);
        checkOutput("t2_addr", 32'(fb_addr_out), 0);
        checkOutput("t2_data", 32'(fb_data_out), 32'(pix(0)));
        checkOutput("t2_ovf", 32'(overflow_out), 1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) begin
            acc = color_ready_out && (sent < 8);
            applyStimulus(1'b0, sent < 8, pix(sent), 1'b1);
            if (acc) sent++;
        end
        checkOutput("t2_writes", writes, 8);
        checkOutput("t2_done_cnt", done_cnt, 1);
        checkOutput("t2_addr_end", 32'(fb_addr_out), 8);
        checkOutput("t2_ovf_sticky", 32'(overflow_out), 1);

        // Full FIFO with toggling ack and a stray frame_start mid-frame.
        startFrame();
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_fill_ready", 32'(color_ready_out), 1);
            applyStimulus(1'b0, 1'b1, pix(sent), 1'b0);
            sent++;
        end
        checkOutput("t3_full", 32'(color_ready_out), 0);
        for (int k = 0; k < 80 && done_cnt == 0; k++) begin
            acc = color_ready_out && (sent < 8);
            applyStimulus(k == 3, acc, pix(sent), (k % 2) == 0);
            if (acc) sent++;
        end
        checkOutput("t3_writes", writes, 8);
        checkOutput("t3_done_cnt", done_cnt, 1);
        checkOutput("t3_ovf", 32'(overflow_out), 0);
        checkOutput("t3_addr_end", 32'(fb_addr_out), 8);

        // Reset mid-frame with three pixels written and two buffered.
        startFrame();
        for (int k = 0; k < 30 && writes < 3; k++) begin
            acc = color_ready_out;
            applyStimulus(1'b0, 1'b1, pix(sent), 1'b1);
            if (acc) sent++;
        end
        for (int k = 0; k < 10 && exp_q.size() < 2; k++) begin
            acc = color_ready_out;
            applyStimulus(1'b0, 1'b1, pix(sent), 1'b0);
            if (acc) sent++;
        end
        checkOutput("t5_buffered", exp_q.size(), 2);
        checkOutput("t5_pre_addr", 32'(fb_addr_out), 3);
        checkOutput("t5_pre_data", 32'(fb_data_out), 32'(pix(3)));
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
        reset = 1'b0;
        checkAllZero("t5_rst");
        exp_q.delete();
        repeat (3) applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
        checkOutput("t5_no_done", done_cnt, 0);
        checkOutput("t5_no_we", 32'(fb_we_out), 0);
        startFrame();
        checkOutput("t5_restart_addr", 32'(fb_addr_out), 0);
        for (int k = 0; k < 40 && done_cnt == 0; k++) begin
            acc = color_ready_out && (sent < 8);
            applyStimulus(1'b0, sent < 8, pix(sent + 16), 1'b1);
            if (acc) sent++;
        end
        checkOutput("t5_writes", writes, 8);
        checkOutput("t5_done_cnt", done_cnt, 1);

        // Full-size frame on the default instance; pixel k carries value k.
        b_frame_start = 1'b1;
        @(negedge clk);
        b_frame_start = 1'b0;
        for (int k = 0; k < 90000 && b_post < 5; k++) begin
            b_valid = (b_sent < BIG_PIX) && b_ready && ($urandom_range(31) != 0);
            b_color = 24'(b_sent);
            b_ack   = ($urandom_range(31) != 0);
            if (b_done) b_done_cnt++;
            if (b_done_cnt > 0) b_post++;
            if (b_we && b_ack) begin
                if ((b_addr != 17'(b_writes)) || (b_data != 24'(b_writes))) b_err++;
                b_last_addr = b_addr;
                b_writes++;
            end
            if (b_valid) b_sent++;
            @(negedge clk);
        end
        b_valid = 1'b0;
        b_ack   = 1'b0;
        checkOutput("big_seq_errors", b_err, 0);
        checkOutput("big_writes", b_writes, BIG_PIX);
        checkOutput("big_last_addr", 32'(b_last_addr), BIG_PIX - 1);
        checkOutput("big_done_cnt", b_done_cnt, 1);
        checkOutput("big_ovf", 32'(b_ovf), 0);
        checkOutput("big_addr_end", 32'(b_addr), BIG_PIX);
        checkOutput("big_busy_end", 32'(b_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Downstream stage of the Lambertian shader: it takes one shaded `Color` per pixel and writes it into the framebuffer memory in raster order. Incoming pixels are buffered in a small FIFO so the shader pipeline can keep running while memory stalls. The block generates linear framebuffer addresses, signals when the last pixel of a frame has been written, and flags dropped pixels.

## Interface
Parameters:
- `H_RES`, 320: pixels per line.
- `V_RES`, 240: lines per frame.
- `RGB_WIDTH`, 8: bits per colour channel; must match `Color`.
- `FIFO_DEPTH`, 4: pixel FIFO entries; power of two, ≥2.
- `ADDR_WIDTH`, 17: framebuffer address width; must satisfy 2^ADDR_WIDTH ≥ H_RES*V_RES.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse that arms a new frame.
- `color_in`  in  `Color` (3*RGB_WIDTH)  shaded pixel from the shader's `finalColor_out`.
- `color_valid_in`  in  1  `color_in` is valid (the shader's `valid_out`).
- `color_ready_out`  out  1  the block accepts `color_in` this cycle.
- `fb_addr_out`  out  ADDR_WIDTH  linear write address, y*H_RES+x.
- `fb_data_out`  out  3*RGB_WIDTH  packed {r,g,b}, with r in the MSBs.
- `fb_we_out`  out  1  write request.
- `fb_ack_in`  in  1  memory accepts the write this cycle.
- `busy_out`  out  1  state is ACTIVE or DRAIN.
- `frame_done_out`  out  1  one-cycle pulse after the last write is acked.
- `overflow_out`  out  1  sticky; a valid pixel was dropped.

## Operation
- States: IDLE, ACTIVE, DRAIN, DONE.
- **IDLE**
  - `color_ready_out`=0 and input is ignored.
  - `frame_start`=1: go to ACTIVE; clear the input count, `fb_addr_out`, and `overflow_out`.
- **ACTIVE**
  - `color_ready_out` = !fifo_full.
  - A push happens when `color_valid_in && color_ready_out`; the input count increments on each push.
  - When a push brings the input count to H_RES*V_RES, go to DRAIN.
- **DRAIN**
  - `color_ready_out`=0.
  - When the FIFO is empty (including the cycle the last pop empties it), go to DONE.
- **DONE**
  - `frame_done_out`=1 for exactly this one cycle, then go to IDLE.
- **Write side (ACTIVE and DRAIN)**
  - `fb_we_out` = !fifo_empty.
  - `fb_data_out` = FIFO head, held stable along with `fb_addr_out` until acked.
  - A pop happens on `fb_we_out && fb_ack_in`: `fb_addr_out` increments by 1.
  - Raster order is implied by the linear address; no separate x/y counters are needed.
- **Dropped pixels**
  - `color_valid_in`=1 while `color_ready_out`=0 in ACTIVE: the pixel is dropped, `overflow_out` is set, and the count does not advance.
  - `color_valid_in` in IDLE, DRAIN or DONE is ignored silently.
- **FIFO**
  - Push and pop may occur in the same cycle.
  - Push when full is impossible because ready gates it.
  - `fb_ack_in` while `fb_we_out`=0 has no effect.
- `frame_start` in ACTIVE, DRAIN or DONE is ignored.
- `reset` mid-frame:
  - Returns to IDLE and flushes the FIFO.
  - Discards pending pixels with no `frame_done_out`.

## Timing
- Reset values:
  - All outputs are 0.
  - `fb_addr_out`=0, state IDLE, FIFO empty, `overflow_out`=0.
- `frame_start` at edge N: `busy_out` and `color_ready_out` are 1 from cycle N+1.
- Push at edge N into an empty FIFO: `fb_we_out`=1 with that pixel in cycle N+1. There is no combinational input-to-output path.
- With `fb_ack_in` tied 1: sustained throughput is 1 pixel/cycle and the FIFO never fills.
- Last pop at edge E: state is DONE and `frame_done_out`=1 in cycle E+1; IDLE and `busy_out`=0 in cycle E+2.
- `fb_addr_out` after a frame equals H_RES*V_RES until the next `frame_start` clears it.

## Test plan
(H_RES=4, V_RES=2, FIFO_DEPTH=4 unless stated.)
- **Full frame, no stall.** `frame_start`, then 8 back-to-back pixels {r=i, g=2i, b=3i} with ack=1 → writes to addresses 0..7 with data 0x000000, 0x010203, …, 0x070E15, one per cycle; `frame_done_out` one cycle after the 8th ack.
- **Memory stall.** ack=0 for 10 cycles while valid=1 → exactly 4 pixels accepted, then ready=0; `fb_data_out`/`fb_addr_out` are held at pixel 0/addr 0; further valids set `overflow_out`=1. Then ack=1 → FIFO drains in order.
- **Simultaneous push/pop on a full FIFO with ack toggling 1/0.** No pixel is lost or duplicated; addresses 0..7 are strictly sequential.
- **Ignored events.** Pixels before `frame_start` → ignored, no write, `overflow_out`=0. `frame_start` pulsed mid-frame → no effect, addresses continue.
- **Reset mid-frame.** `reset` after 3 pixels written and 2 buffered → all outputs 0 next cycle, no `frame_done_out`. A new `frame_start` restarts at addr 0.
- **Default parameters (320×240).** 76800 pixels with random valid/ack gaps → last write addr 76799, a single `frame_done_out` pulse, `overflow_out`=0.
